// File: rtl/delay_ctrl_pkg.sv
// Shared definitions for the delay-chain sharing arbiter: FSM state encoding
// and default sizing constants.
package delay_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT     = 255;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level; cleared by rst.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    (* keep = "true", dont_touch = "true" *) logic [STAGES-1:0] sync_q;

    // Shift the raw level through STAGES flops; the oldest flop is the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(d_i);
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/delay_share_arb.sv
// Round-robin arbiter sharing one self-timed delay chain among N_REQ
// requesters. A grant launches a rising edge into the chain, waits for it to
// come back, launches the falling edge, waits again, then acknowledges.
//
// Handshake: req[i] is a level held by requester i until it sees ack[i]
// (a one-cycle pulse). ack_err is meaningful only in the ack cycle. A req
// dropped before being granted is simply never granted; once granted the
// transaction always runs to its ack.
module delay_share_arb
    import delay_ctrl_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [N_REQ-1:0]                              req,
    output logic [N_REQ-1:0]                              ack,
    output logic                                          ack_err,
    output logic                                          dly_inR,
    input  logic                                          dly_outR,
    output logic                                          busy,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0]  grant_id,
    output state_t                                        dbg_state
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              dly_inR_q, dly_inR_d;
    logic              busy_q, busy_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              ack_err_q, ack_err_d;

    logic              dly_s;
    logic              pick_valid;
    logic [GW-1:0]     pick;
    logic [GW-1:0]     cand;

    // Raw chain return is only ever seen through the synchronizer.
    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (dly_outR),
        .q_o (dly_s)
    );

    // Round-robin search starting just after the last granted requester.
    // Scanning from farthest to nearest lets the nearest hit win.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = GW'((int'(last_q) + k) % N_REQ);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    // Next-state logic for the FSM, timeout counter and error flag, plus the
    // next values of every registered output.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_RISE;
                end
            end
            ST_RISE: begin
                if (dly_s) begin
                    cnt_d   = '0;
                    state_d = ST_FALL;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    // Give up on the rising edge and drain the chain anyway.
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_FALL;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_FALL: begin
                if (!dly_s) begin
                    state_d = ST_ACK;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_ACK: begin
                last_d  = grant_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state implies.
        dly_inR_d = (state_d == ST_RISE);
        busy_d    = (state_d != ST_IDLE);
        ack_d     = '0;
        ack_err_d = 1'b0;
        if (state_d == ST_ACK) begin
            ack_d[grant_d] = 1'b1;
            ack_err_d      = err_d;
        end
    end

    // State and output registers; reset leaves requester 0 with top priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= GW'(N_REQ - 1);
            cnt_q     <= '0;
            err_q     <= 1'b0;
            dly_inR_q <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= '0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            dly_inR_q <= dly_inR_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign dly_inR   = dly_inR_q;
    assign busy      = busy_q;
    assign ack       = ack_q;
    assign ack_err   = ack_err_q;
    assign grant_id  = grant_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_delay_share_arb.sv
// Bench for delay_share_arb: delay-chain model, directed scenarios and a
// randomized round-robin run checked against a transaction-level model.
module tb_delay_share_arb;
    import delay_ctrl_pkg::*;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int TO = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] ack;
    logic         ack_err;
    logic         dly_inR;
    logic         dly_outR;
    logic         busy;
    logic [1:0]   grant_id;
    state_t       dbg_state;

    int           tests = 0;
    int           fails = 0;

    // Chain model: dly_outR repeats dly_inR chain_d cycles later, or sticks at 1.
    int           chain_d = 3;
    logic         stuck = 1'b0;
    logic [15:0]  chain_sr = '0;

    int           model_last;
    logic [3:0]   exp_q[$];
    logic [3:0]   a, mask, expv, prev_a, seen;
    logic         e;
    int           w;

    delay_share_arb #(
        .N_REQ       (N),
        .SYNC_STAGES (S),
        .TIMEOUT     (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .ack_err   (ack_err),
        .dly_inR   (dly_inR),
        .dly_outR  (dly_outR),
        .busy      (busy),
        .grant_id  (grant_id),
        .dbg_state (dbg_state)
    );

    // clock / chain model
    always #5 clk = ~clk;

    always @(posedge clk) chain_sr <= {chain_sr[14:0], dly_inR};

    assign dly_outR = stuck | chain_sr[chain_d-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        tests++;
        assert (obs === expd) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
        end
    endtask

    // Round-robin rule: first requester after 'last', wrapping.
    function automatic int rr_next(input logic [3:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        req   = '0;
        stuck = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        model_last = N - 1;
    endtask

    task automatic wait_ack(input string tag, output logic [3:0] ao, output logic eo);
        ao = '0;
        eo = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                ao = ack;
                eo = ack_err;
                return;
            end
        end
        tests++;
        fails++;
        $error("FAIL %s: no ack within 200 cycles, observed ack %0h expected a pulse", tag, ack);
    endtask

    task automatic wait_launch(input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dly_inR === 1'b1) return;
        end
        tests++;
        fails++;
        $error("FAIL %s: dly_inR never rose, observed %0b expected 1", tag, dly_inR);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        model_last = N - 1;

        // ---- reset state
        repeat (3) @(negedge clk);
        check("rst_ack",     32'(ack),       32'd0);
        check("rst_ack_err", 32'(ack_err),   32'd0);
        check("rst_busy",    32'(busy),      32'd0);
        check("rst_gid",     32'(grant_id),  32'd0);
        check("rst_dly_inR", 32'(dly_inR),   32'd0);
        check("rst_state",   32'(dbg_state), 32'(ST_IDLE));

        // ---- single request, D=3, exact launch latency
        chain_d = 3;
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        check("single_launch", 32'(dly_inR),  32'd1);
        check("single_busy",   32'(busy),     32'd1);
        check("single_gid",    32'(grant_id), 32'(rr_next(4'b0001, model_last)));
        wait_ack("single", a, e);
        check("single_ack",     32'(a), 32'b0001);
        check("single_ack_err", 32'(e), 32'd0);
        req = '0;
        @(negedge clk);
        check("single_ack_pulse", 32'(ack),  32'd0);
        check("single_idle_busy", 32'(busy), 32'd0);

        // ---- contention, all four held, D=2
        chain_d = 2;
        do_reset();
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            w = rr_next(4'b1111, model_last);
            exp_q.push_back(4'(1 << w));
            model_last = w;
        end
        prev_a = '0;
        for (int t = 0; t < 5; t++) begin
            wait_ack("contend", a, e);
            expv = exp_q.pop_front();
            check("contend_ack", 32'(a), 32'(expv));
            check("contend_not_repeat", 32'(a != prev_a), 32'd1);
            prev_a = a;
        end
        req = '0;
        @(negedge clk);

        // ---- randomized round-robin against the model
        do_reset();
        chain_d = $urandom_range(1, 4);
        mask = 4'($urandom_range(1, 15));
        req = mask;
        for (int t = 0; t < 30; t++) begin
            w = rr_next(mask, model_last);
            exp_q.push_back(4'(1 << w));
            wait_ack("rnd", a, e);
            expv = exp_q.pop_front();
            check("rnd_ack",     32'(a),        32'(expv));
            check("rnd_ack_err", 32'(e),        32'd0);
            check("rnd_gid",     32'(grant_id), 32'(w));
            model_last = w;
            // Unserved requesters keep holding; others may (re)request.
            mask = (mask & ~expv) | 4'($urandom_range(0, 15));
            if (mask == '0) mask = 4'(1 << $urandom_range(0, 3));
            req = mask;
        end
        req = '0;

        // ---- chain stuck high after launch: FALL timeout
        chain_d = 3;
        do_reset();
        req = 4'b0001;
        wait_launch("stuck");
        stuck = 1'b1;
        wait_ack("stuck", a, e);
        check("stuck_ack",     32'(a),       32'b0001);
        check("stuck_ack_err", 32'(e),       32'd1);
        check("stuck_dly_inR", 32'(dly_inR), 32'd0);
        req = '0;
        stuck = 1'b0;
        @(negedge clk);
        check("stuck_idle", 32'(busy), 32'd0);

        // ---- reset while in RISE aborts without ack
        chain_d = 3;
        do_reset();
        req = 4'b0100;
        wait_launch("rstrise");
        check("rstrise_gid", 32'(grant_id), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        model_last = N - 1;
        check("rstrise_dly_inR", 32'(dly_inR), 32'd0);
        check("rstrise_busy",    32'(busy),    32'd0);
        seen = ack;
        repeat (8) begin
            @(negedge clk);
            seen = seen | ack;
        end
        check("rstrise_no_ack", 32'(seen), 32'd0);
        req = 4'b0101;
        @(negedge clk);
        w = rr_next(4'b0101, model_last);
        check("rstrise_regrant", 32'(grant_id), 32'(w));
        wait_ack("rstrise", a, e);
        check("rstrise_ack",     32'(a), 32'(4'(1 << w)));
        check("rstrise_ack_err", 32'(e), 32'd0);
        model_last = w;
        req = 4'b0100;
        w = rr_next(4'b0100, model_last);
        wait_ack("rstrise2", a, e);
        check("rstrise_ack2", 32'(a), 32'(4'(1 << w)));
        req = '0;

        // ---- withdraw during RISE; newcomer granted next
        chain_d = 2;
        do_reset();
        req = 4'b0010;
        wait_launch("withdraw");
        req = 4'b0100;
        wait_ack("withdraw", a, e);
        check("withdraw_ack",     32'(a), 32'b0010);
        check("withdraw_ack_err", 32'(e), 32'd0);
        @(negedge clk);
        check("withdraw_pulse", 32'(ack), 32'd0);
        wait_ack("withdraw_next", a, e);
        check("withdraw_next_ack", 32'(a), 32'b0100);
        req = '0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
